rob_commit_ctrl: RTL
====================

Name: rob_commit_ctrl

Overview:
16-entry circular reorder buffer that sequences in-order commit into the architectural register file. It allocates ROB positions to issued instructions and captures execution-unit writebacks. It retires the head entry through the register file commit port and raises a flush (rollback) when a mispredicted branch commits. It supplies issue_rob_pos to the register file rename path and is its only commit/rollback source.

Parameters:
ROB_POS_W, 4, width of ROB position; depth = 2**ROB_POS_W (16)
XLEN, 32, data/PC width

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
rdy  in  1  global enable; when 0 all state and outputs frozen
issue_valid  in  1  decoder issues an instruction this cycle
issue_rd  in  5  destination register (0 = no writeback)
alloc_pos  out  ROB_POS_W  position the next issue receives (= tail)
full  out  1  all entries busy; issue ignored
count  out  ROB_POS_W+1  number of busy entries, 0..16
wb_valid  in  1  execution writeback
wb_rob_pos  in  ROB_POS_W  entry being written back
wb_val  in  XLEN  result value
wb_mispredict  in  1  entry is a mispredicted control transfer
wb_target  in  XLEN  correct next PC when wb_mispredict
commit  out  1  one-cycle retire pulse to regfile
commit_rd  out  5  retired destination
commit_val  out  XLEN  retired value
commit_rob_pos  out  ROB_POS_W  retired position
rollback  out  1  one-cycle flush pulse
redirect_pc  out  XLEN  fetch redirect, valid while rollback=1

Behaviour:
- Reset (rst=0, async): head=tail=0, count=0, all busy/ready/mispredict bits 0; commit, commit_rd, commit_val, commit_rob_pos, rollback, redirect_pc all 0. Reset mid-operation discards all entries immediately.
- All updates below occur on rising clk with rst=1 and rdy=1; with rdy=0 every register holds, including commit/rollback (the consumer is gated by the same rdy, so each pulse is seen on exactly one enabled edge).
- Per-entry state: busy, ready, mispredict, rd[4:0], val, target.
- full = (count==16); alloc_pos = tail, both combinational from registers.
- Issue: if issue_valid && !full && !rollback: entry[tail] <- busy=1, ready=0, mispredict=0, rd=issue_rd; tail <- tail+1 (wraps 15->0). Issue while full or while rollback=1 is dropped, no state change.
- Writeback: if wb_valid && entry[wb_rob_pos].busy: ready=1, val=wb_val, mispredict=wb_mispredict, target=wb_target. Writeback to a non-busy entry is ignored. A writeback and an issue to the same position in one cycle cannot occur (entry not busy until issued); the issue wins.
- Commit decision uses registered state only: if entry[head].busy && entry[head].ready: commit<=1, commit_rd<=rd, commit_val<=val, commit_rob_pos<=head; entry[head].busy<=0; head<=head+1. Otherwise commit<=0 (rd/val/pos hold last values). At most one commit per cycle.
- Latency: writeback sampled at edge N -> commit high after edge N+1 at the earliest. Issue at edge N -> entry can commit no earlier than edge N+2.
- count <= count + issued - committed; simultaneous issue and commit keeps count constant. Issue is still blocked when full, even if a commit occurs that cycle.
- Mispredict commit: when the committing head entry has mispredict=1, in the same edge set rollback<=1 and redirect_pc<=target. Also clear all busy/ready bits and set head=tail=0, count=0. Any issue or writeback that edge is discarded. The branch itself still commits (commit=1 with its rd/val). rollback is a one-cycle pulse, cleared on the next enabled edge.
- Non-mispredict cycles: rollback<=0, redirect_pc holds.

Test Plan:
- Reset: drive rst=0 mid-run with 5 busy entries -> immediately count=0, alloc_pos=0, commit=0, rollback=0.
- In-order: issue rd=5,6,7 (pos 0,1,2); writeback pos2 val=0x33, then pos0 val=0x11, then pos1 val=0x22 -> commits in order pos0/rd5/0x11, pos1/rd6/0x22, pos2/rd7/0x33 on consecutive cycles after pos1 writeback.
- Full/wrap: 16 issues -> full=1, count=16; 17th issue ignored. Writeback and commit pos0 -> full=0; next issue receives alloc_pos=0 (wrap).
- Simultaneous: with count=3, issue and commit in same cycle -> count stays 3, tail and head both advance.
- Rollback: issue branch rd=1 (pos0) and rd=2 (pos1); writeback pos1, then pos0 with mispredict=1, target=0x100 -> one cycle with commit=1 rd=1, rollback=1, redirect_pc=0x100. Next cycle count=0, alloc_pos=0, pos1 never commits.
- Stall: hold rdy=0 for 3 cycles while commit=1 -> commit and head unchanged; the pulse clears after the first rdy=1 edge.

Source files
------------

// File: rtl/rob_commit_ctrl.sv
// ---------------------------------------------------------------------------
// rob_commit_ctrl -- 16-entry circular reorder buffer with in-order commit.
//
// Allocates ROB positions to issued instructions, captures execution
// writebacks, retires the head entry into the architectural register file
// and raises a one-cycle rollback when a mispredicted branch retires.
//
// Ports:
//   clk, rst            clock (rising edge), async active-low reset
//   rdy                 global enable; 0 freezes every register
//   issue_valid/_rd     decoder issue request and its destination register
//   alloc_pos, full,    tail position, full flag and occupancy (0..16),
//   count               all combinational from registers
//   wb_*                execution writeback (position, value, mispredict,
//                       corrected target)
//   commit, commit_*    registered one-cycle retire pulse and its payload
//   rollback,           registered one-cycle flush pulse and the fetch
//   redirect_pc         redirect target
// ---------------------------------------------------------------------------

// Per-entry storage. Control priority: flush > allocate > writeback/retire.
module rob_commit_entry #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rdy,
    input  logic            alloc,
    input  logic [4:0]      alloc_rd,
    input  logic            wb,
    input  logic [XLEN-1:0] wb_val,
    input  logic            wb_mispredict,
    input  logic [XLEN-1:0] wb_target,
    input  logic            retire,
    input  logic            flush,
    output logic            busy,
    output logic            ready,
    output logic            mispredict,
    output logic [4:0]      rd,
    output logic [XLEN-1:0] val,
    output logic [XLEN-1:0] target
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy       <= 1'b0;
            ready      <= 1'b0;
            mispredict <= 1'b0;
            rd         <= '0;
            val        <= '0;
            target     <= '0;
        end else if (rdy) begin
            if (flush) begin
                busy       <= 1'b0;
                ready      <= 1'b0;
                mispredict <= 1'b0;
            end else if (alloc) begin
                busy       <= 1'b1;
                ready      <= 1'b0;
                mispredict <= 1'b0;
                rd         <= alloc_rd;
            end else begin
                if (wb) begin
                    ready      <= 1'b1;
                    val        <= wb_val;
                    mispredict <= wb_mispredict;
                    target     <= wb_target;
                end
                // Retire comes last so it wins over a late duplicate writeback.
                if (retire) begin
                    busy  <= 1'b0;
                    ready <= 1'b0;
                end
            end
        end
    end

endmodule

module rob_commit_ctrl #(
    parameter int ROB_POS_W = 4,
    parameter int XLEN      = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy,
    input  logic                 issue_valid,
    input  logic [4:0]           issue_rd,
    output logic [ROB_POS_W-1:0] alloc_pos,
    output logic                 full,
    output logic [ROB_POS_W:0]   count,
    input  logic                 wb_valid,
    input  logic [ROB_POS_W-1:0] wb_rob_pos,
    input  logic [XLEN-1:0]      wb_val,
    input  logic                 wb_mispredict,
    input  logic [XLEN-1:0]      wb_target,
    output logic                 commit,
    output logic [4:0]           commit_rd,
    output logic [XLEN-1:0]      commit_val,
    output logic [ROB_POS_W-1:0] commit_rob_pos,
    output logic                 rollback,
    output logic [XLEN-1:0]      redirect_pc
);

    localparam int DEPTH = 1 << ROB_POS_W;
    localparam logic [ROB_POS_W:0] CNT_FULL = (ROB_POS_W+1)'(DEPTH);

    typedef struct packed {
        logic            busy;
        logic            ready;
        logic            mispredict;
        logic [4:0]      rd;
        logic [XLEN-1:0] val;
        logic [XLEN-1:0] target;
    } rob_entry_t;

    rob_entry_t [DEPTH-1:0] ent;
    rob_entry_t             head_ent;

    logic [ROB_POS_W-1:0] head, tail;
    logic [ROB_POS_W:0]   cnt;

    logic do_commit, do_flush, do_issue, wb_hit;

    assign alloc_pos = tail;
    assign count     = cnt;
    assign full      = (cnt == CNT_FULL);

    // Commit looks only at registered head state, so a writeback needs one
    // extra edge before its entry can retire.
    assign head_ent  = ent[head];
    assign do_commit = head_ent.busy & head_ent.ready;
    assign do_flush  = do_commit & head_ent.mispredict;

    // A retiring mispredict discards everything else arriving on that edge;
    // issue is also held off for the cycle rollback is visible downstream.
    assign do_issue  = issue_valid & ~full & ~rollback & ~do_flush;
    assign wb_hit    = wb_valid & ent[wb_rob_pos].busy & ~do_flush;

    for (genvar i = 0; i < DEPTH; i++) begin : gen_entry
        rob_commit_entry #(.XLEN(XLEN)) u_entry (
            .clk           (clk),
            .rst           (rst),
            .rdy           (rdy),
            .alloc         (do_issue && (tail == ROB_POS_W'(i))),
            .alloc_rd      (issue_rd),
            .wb            (wb_hit && (wb_rob_pos == ROB_POS_W'(i))),
            .wb_val        (wb_val),
            .wb_mispredict (wb_mispredict),
            .wb_target     (wb_target),
            .retire        (do_commit && (head == ROB_POS_W'(i))),
            .flush         (do_flush),
            .busy          (ent[i].busy),
            .ready         (ent[i].ready),
            .mispredict    (ent[i].mispredict),
            .rd            (ent[i].rd),
            .val           (ent[i].val),
            .target        (ent[i].target)
        );
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head           <= '0;
            tail           <= '0;
            cnt            <= '0;
            commit         <= 1'b0;
            commit_rd      <= '0;
            commit_val     <= '0;
            commit_rob_pos <= '0;
            rollback       <= 1'b0;
            redirect_pc    <= '0;
        end else if (rdy) begin
            commit   <= do_commit;
            rollback <= do_flush;
            if (do_commit) begin
                commit_rd      <= head_ent.rd;
                commit_val     <= head_ent.val;
                commit_rob_pos <= head;
            end
            if (do_flush) begin
                redirect_pc <= head_ent.target;
                head        <= '0;
                tail        <= '0;
                cnt         <= '0;
            end else begin
                if (do_commit) head <= head + 1'b1;
                if (do_issue)  tail <= tail + 1'b1;
                cnt <= cnt + (ROB_POS_W+1)'(do_issue) - (ROB_POS_W+1)'(do_commit);
            end
        end
    end

endmodule
